gate_vector_gen: RTL
====================

Name: gate_vector_gen

Overview:
- Stimulus generator sitting directly upstream of the gate test top.
- Produces three pseudo-random operand vectors per transaction (in1/in2/in3 feed for the inv/and2/nand2/mux2/nor2 instances) from three 64-bit Galois LFSRs.
- Uses a valid/ready handshake and emits a programmed number of vectors per run, so the gate block can be exercised on-chip without a C-TB driving every input.

Parameters:
- WIDTH, 64, operand width; 1..64; outputs are the low WIDTH bits of each LFSR.
- CNT_W, 32, width of vector-count request and counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle run request; sampled only in IDLE.
- seed  input  64  LFSR seed; sampled with start.
- num_vec  input  CNT_W  number of vectors to emit; sampled with start.
- out_valid  output  1  operand vectors valid.
- out_ready  input  1  consumer accepts the current vectors.
- out_a  output  WIDTH  operand 1 (to in1).
- out_b  output  WIDTH  operand 2 (to in2).
- out_c  output  WIDTH  operand 3 (to in3; bit 0 is mux select).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse at end of run.
- vec_count  output  CNT_W  vectors accepted in the current or last run.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE; out_valid=0, busy=0, done=0, vec_count=0; LFSR A/B/C=0; out_a/b/c=0.
- LFSR step (Galois, right shift), with poly x^64+x^63+x^61+x^60+1 and mask M=0xD800_0000_0000_0000: next = (s>>1) ^ (s[0] ? M : 0).
- Seeding on start:
  - A=seed, B=~seed, C=seed^0x5555_5555_5555_5555.
  - Any of the three that is zero is loaded with 0x1 instead (lock-up avoidance).
- FSM states IDLE, RUN, DONE:
  - IDLE: start=1 and num_vec!=0: load LFSRs, vec_count=0, next state RUN. out_valid=1 and busy=1 from the following cycle.
  - IDLE: start=1 and num_vec==0: vec_count=0, next state DONE, no vectors emitted.
  - IDLE: start=0: hold.
  - RUN: out_valid=1 continuously.
  - RUN, transfer (out_valid & out_ready): all three LFSRs step, vec_count++.
  - RUN: if the transfer brings vec_count to num_vec, next state DONE and out_valid=0 next cycle.
  - RUN, no transfer: out_a/b/c and vec_count hold exactly (AXI-style stability).
  - DONE: done=1 for exactly one cycle, busy=0, out_valid=0, next state IDLE. vec_count holds its final value until the next start.
- start in RUN or DONE is ignored. seed and num_vec are only captured in IDLE.
- Latency: start -> out_valid is 1 cycle. Last transfer -> done is 1 cycle. Each transfer advances operands in the next cycle, giving a throughput of one vector per cycle with ready held high.
- out_a/b/c = LFSR[WIDTH-1:0], registered directly with no combinational path from out_ready.
- vec_count never wraps: the run ends at num_vec ≤ 2^CNT_W-1.
- Reset mid-run: immediate return to the reset values above. No done pulse is generated.

Test Plan:
- rst, then start with seed=0x1, num_vec=1, ready=1:
  - first beat: out_a=0x1, out_b=0xFFFF_FFFF_FFFF_FFFE, out_c=0x5555_5555_5555_5554;
  - done pulses 1 cycle after the transfer; vec_count=1.
- seed=0x1, num_vec=2, ready=1:
  - second beat: out_a=0xD800_0000_0000_0000, out_b=0x7FFF_FFFF_FFFF_FFFF, out_c=0x2AAA_AAAA_AAAA_AAAA;
  - done after beat 2.
- Backpressure: num_vec=3, ready toggled 1,0,0,1,1:
  - outputs stable during ready=0;
  - exactly 3 transfers, with operand sequences identical to the ready=1 run;
  - done 1 cycle after the 3rd transfer.
- num_vec=0: start -> done pulse next cycle, out_valid never asserted, vec_count=0.
- seed=0x0: A loads 0x1, B=0xFFFF_FFFF_FFFF_FFFF, C=0x5555_5555_5555_5555. A second start during RUN has no effect on count or sequence.
- Assert rst on the 5th beat of a num_vec=10 run: out_valid/busy/vec_count go to 0 immediately, no done pulse. A new start afterwards runs normally.

Source files
------------

// File: rtl/gate_vector_gen.sv
// gate_vector_gen: on-chip stimulus source for the gate test top.
// Three 64-bit Galois LFSRs supply operand vectors over a valid/ready
// handshake; a run emits a programmed number of vectors, then pulses done.
module gate_vector_gen #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      seed,
    input  logic [CNT_W-1:0] num_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // x^64+x^63+x^61+x^60+1, right-shifting Galois form
    localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;
    localparam logic [63:0] SEED_ALT  = 64'h5555_5555_5555_5555;

    state_t           r_state;
    state_t           w_state_next;
    logic [63:0]      r_lfsr_a;
    logic [63:0]      r_lfsr_b;
    logic [63:0]      r_lfsr_c;
    logic [CNT_W-1:0] r_vec_count;
    logic [CNT_W-1:0] r_num_vec;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_start_run;
    logic             w_start_empty;
    logic             w_xfer;
    logic             w_last;

    function automatic logic [63:0] f_step(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 64'd0);
    endfunction

    // An all-zero Galois LFSR never leaves zero, so substitute 1
    function automatic logic [63:0] f_nonzero(input logic [63:0] s);
        return (s == 64'd0) ? 64'd1 : s;
    endfunction

    assign w_start_run   = (r_state == S_IDLE) && start && (num_vec != '0);
    assign w_start_empty = (r_state == S_IDLE) && start && (num_vec == '0);
    assign w_xfer        = (r_state == S_RUN) && out_ready;
    assign w_cnt_inc     = r_vec_count + CNT_W'(1);
    assign w_last        = w_xfer && (w_cnt_inc == r_num_vec);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_run) begin
                    w_state_next = S_RUN;
                end else if (w_start_empty) begin
                    w_state_next = S_DONE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // LFSR seeding/stepping and vector counting; everything holds on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr_a    <= '0;
            r_lfsr_b    <= '0;
            r_lfsr_c    <= '0;
            r_vec_count <= '0;
            r_num_vec   <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_vec_count <= '0;
                r_num_vec   <= num_vec;
            end
            if (w_start_run) begin
                r_lfsr_a <= f_nonzero(seed);
                r_lfsr_b <= f_nonzero(~seed);
                r_lfsr_c <= f_nonzero(seed ^ SEED_ALT);
            end
        end else if (w_xfer) begin
            r_lfsr_a    <= f_step(r_lfsr_a);
            r_lfsr_b    <= f_step(r_lfsr_b);
            r_lfsr_c    <= f_step(r_lfsr_c);
            r_vec_count <= w_cnt_inc;
        end
    end

    assign out_a     = r_lfsr_a[WIDTH-1:0];
    assign out_b     = r_lfsr_b[WIDTH-1:0];
    assign out_c     = r_lfsr_c[WIDTH-1:0];
    assign vec_count = r_vec_count;

endmodule
